// File: rtl/axi_slave_ram.sv
// AXI4 slave backed by a synchronous single-clock RAM.
// Independent read and write FSMs, one outstanding burst per direction, INCR bursts only.
module axi_slave_ram #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH  = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     axi_aw_id_i,
  input  logic [ADDR_WIDTH-1:0]   axi_aw_addr_i,
  input  logic [7:0]              axi_aw_len_i,
  input  logic [2:0]              axi_aw_size_i,
  input  logic                    axi_aw_valid_i,
  output logic                    axi_aw_ready_o,
  input  logic                    axi_w_valid_i,
  output logic                    axi_w_ready_o,
  input  logic [DATA_WIDTH-1:0]   axi_w_data_i,
  input  logic [DATA_WIDTH/8-1:0] axi_w_strb_i,
  input  logic                    axi_w_last_i,
  output logic                    axi_b_valid_o,
  input  logic                    axi_b_ready_i,
  output logic [1:0]              axi_b_resp_o,
  output logic [ID_WIDTH-1:0]     axi_b_id_o,
  input  logic [ID_WIDTH-1:0]     axi_ar_id_i,
  input  logic [ADDR_WIDTH-1:0]   axi_ar_addr_i,
  input  logic [7:0]              axi_ar_len_i,
  input  logic [2:0]              axi_ar_size_i,
  input  logic                    axi_ar_valid_i,
  output logic                    axi_ar_ready_o,
  output logic                    axi_r_valid_o,
  input  logic                    axi_r_ready_i,
  output logic [DATA_WIDTH-1:0]   axi_r_data_o,
  output logic [1:0]              axi_r_resp_o,
  output logic                    axi_r_last_o,
  output logic [ID_WIDTH-1:0]     axi_r_id_o
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MemBytes = (ADDR_WIDTH + 1)'(MEM_DEPTH * StrbW);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic {RIdle, RData} r_state_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < MemBytes;
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[OffW +: IdxW];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] beat_incr(input logic [2:0] size);
    return ADDR_WIDTH'(1) << size;
  endfunction

  // Holds both address-ready outputs low until the first edge after reset release.
  logic out_of_reset_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_of_reset_q <= 1'b0;
    end else begin
      out_of_reset_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] ram_rdata_q;
  logic                  r_oor;

  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_cnt_d   = r_cnt_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_id_d    = r_id_q;
    rd_en     = 1'b0;
    rd_addr   = r_addr_q;
    unique case (r_state_q)
      RIdle: begin
        if (axi_ar_valid_i && out_of_reset_q) begin
          r_state_d = RData;
          r_addr_d  = axi_ar_addr_i;
          r_cnt_d   = 8'd0;
          r_len_d   = axi_ar_len_i;
          r_size_d  = axi_ar_size_i;
          r_id_d    = axi_ar_id_i;
          rd_en     = 1'b1;
          rd_addr   = axi_ar_addr_i;
        end
      end
      RData: begin
        if (axi_r_ready_i) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = RIdle;
          end else begin
            // Prefetch the next beat so it is presented on the following cycle.
            r_addr_d = r_addr_q + beat_incr(r_size_q);
            r_cnt_d  = r_cnt_q + 8'd1;
            rd_en    = 1'b1;
            rd_addr  = r_addr_d;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= RIdle;
      r_addr_q  <= '0;
      r_cnt_q   <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_id_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_cnt_q   <= r_cnt_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_id_q    <= r_id_d;
    end
  end

  assign r_oor          = !in_range(r_addr_q);
  assign axi_ar_ready_o = out_of_reset_q && (r_state_q == RIdle);
  assign axi_r_valid_o  = (r_state_q == RData);
  assign axi_r_data_o   = (axi_r_valid_o && !r_oor) ? ram_rdata_q : '0;
  assign axi_r_resp_o   = (axi_r_valid_o && r_oor) ? RespSlvErr : RespOkay;
  assign axi_r_last_o   = axi_r_valid_o && (r_cnt_q == r_len_q);
  assign axi_r_id_o     = r_id_q;

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [2:0]            w_size_q, w_size_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic                  w_err_q, w_err_d;
  logic                  wr_en;
  logic                  w_beat_last;

  assign w_beat_last = (w_cnt_q == w_len_q);

  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_cnt_d   = w_cnt_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_id_d    = w_id_q;
    w_err_d   = w_err_q;
    wr_en     = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (axi_aw_valid_i && out_of_reset_q) begin
          w_state_d = WData;
          w_addr_d  = axi_aw_addr_i;
          w_cnt_d   = 8'd0;
          w_len_d   = axi_aw_len_i;
          w_size_d  = axi_aw_size_i;
          w_id_d    = axi_aw_id_i;
          w_err_d   = 1'b0;
        end
      end
      WData: begin
        if (axi_w_valid_i) begin
          wr_en   = in_range(w_addr_q);
          // Sticky error: any out-of-range beat or a misplaced WLAST.
          w_err_d = w_err_q || !in_range(w_addr_q) || (axi_w_last_i != w_beat_last);
          if (w_beat_last) begin
            w_state_d = WResp;
          end else begin
            w_addr_d = w_addr_q + beat_incr(w_size_q);
            w_cnt_d  = w_cnt_q + 8'd1;
          end
        end
      end
      WResp: begin
        if (axi_b_ready_i) begin
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= WIdle;
      w_addr_q  <= '0;
      w_cnt_q   <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_id_q    <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_cnt_q   <= w_cnt_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_id_q    <= w_id_d;
      w_err_q   <= w_err_d;
    end
  end

  assign axi_aw_ready_o = out_of_reset_q && (w_state_q == WIdle);
  assign axi_w_ready_o  = (w_state_q == WData);
  assign axi_b_valid_o  = (w_state_q == WResp);
  assign axi_b_resp_o   = (axi_b_valid_o && w_err_q) ? RespSlvErr : RespOkay;
  assign axi_b_id_o     = w_id_q;

  // ---------------------------------------------------------------------------
  // RAM: contents are not reset; a same-cycle read of a written word sees old data.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [IdxW-1:0]       wr_idx;
  logic [IdxW-1:0]       rd_idx;

  assign wr_idx = word_idx(w_addr_q);
  assign rd_idx = word_idx(rd_addr);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < int'(StrbW); i++) begin
        if (axi_w_strb_i[i]) begin
          mem[wr_idx][i*8 +: 8] <= axi_w_data_i[i*8 +: 8];
        end
      end
    end
    if (rd_en && in_range(rd_addr)) begin
      ram_rdata_q <= mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_axi_slave_ram.sv
// Randomized self-checking bench for axi_slave_ram against a byte-level memory model.
module tb_axi_slave_ram;

  localparam int  Depth    = 4096;
  localparam longint MemBytes = longint'(Depth) * 8;

  logic        clk;
  logic        rst_n;
  logic [3:0]  aw_id;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic        aw_valid;
  logic        aw_ready;
  logic        w_valid;
  logic        w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic        b_valid;
  logic        b_ready;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic        ar_valid;
  logic        ar_ready;
  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [3:0]  r_id;

  axi_slave_ram dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .axi_aw_id_i    (aw_id),
    .axi_aw_addr_i  (aw_addr),
    .axi_aw_len_i   (aw_len),
    .axi_aw_size_i  (aw_size),
    .axi_aw_valid_i (aw_valid),
    .axi_aw_ready_o (aw_ready),
    .axi_w_valid_i  (w_valid),
    .axi_w_ready_o  (w_ready),
    .axi_w_data_i   (w_data),
    .axi_w_strb_i   (w_strb),
    .axi_w_last_i   (w_last),
    .axi_b_valid_o  (b_valid),
    .axi_b_ready_i  (b_ready),
    .axi_b_resp_o   (b_resp),
    .axi_b_id_o     (b_id),
    .axi_ar_id_i    (ar_id),
    .axi_ar_addr_i  (ar_addr),
    .axi_ar_len_i   (ar_len),
    .axi_ar_size_i  (ar_size),
    .axi_ar_valid_i (ar_valid),
    .axi_ar_ready_o (ar_ready),
    .axi_r_valid_o  (r_valid),
    .axi_r_ready_i  (r_ready),
    .axi_r_data_o   (r_data),
    .axi_r_resp_o   (r_resp),
    .axi_r_last_o   (r_last),
    .axi_r_id_o     (r_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [63:0] ref_mem [Depth];
  logic [63:0] wr_data [256];
  logic [7:0]  wr_strb [256];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint beat_addr(input logic [31:0] start, input int n, input logic [2:0] size);
    return longint'(start) + longint'(n) * (longint'(1) << size);
  endfunction

  function automatic logic [63:0] model_read(input longint a);
    if (a >= MemBytes) return 64'd0;
    return ref_mem[int'(a / 8)];
  endfunction

  task automatic model_write(input longint a, input logic [63:0] d, input logic [7:0] s);
    if (a >= MemBytes) return;
    for (int i = 0; i < 8; i++) begin
      if (s[i]) ref_mem[int'(a / 8)][i*8 +: 8] = d[i*8 +: 8];
    end
  endtask

  // bad_beat: index of a beat whose WLAST is inverted (-1 for none).
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input int bad_beat, input bit gaps);
    bit exp_err;
    int cnt;
    longint a;
    exp_err = 1'b0;
    @(negedge clk);
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_valid = 1'b1;
    cnt = 0;
    while (!aw_ready && cnt < 100) begin @(negedge clk); cnt++; end
    check_eq("aw_ready_wait", 64'(aw_ready), 64'd1);
    if (!aw_ready) begin aw_valid = 1'b0; return; end
    @(negedge clk);
    aw_valid = 1'b0;
    for (int n = 0; n <= int'(len); n++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      w_valid = 1'b1;
      w_data  = wr_data[n];
      w_strb  = wr_strb[n];
      w_last  = (n == int'(len)) != (n == bad_beat);
      cnt = 0;
      while (!w_ready && cnt < 100) begin @(negedge clk); cnt++; end
      check_eq("w_ready_wait", 64'(w_ready), 64'd1);
      if (!w_ready) begin w_valid = 1'b0; return; end
      a = beat_addr(addr, n, size);
      if (a >= MemBytes || n == bad_beat) exp_err = 1'b1;
      model_write(a, wr_data[n], wr_strb[n]);
      @(negedge clk);
      w_valid = 1'b0;
      w_last  = 1'b0;
    end
    cnt = 0;
    while (!b_valid && cnt < 100) begin @(negedge clk); cnt++; end
    check_eq("b_valid_wait", 64'(b_valid), 64'd1);
    if (!b_valid) return;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_eq("b_valid_hold", 64'(b_valid), 64'd1);
      end
    end
    check_eq("b_resp", 64'(b_resp), exp_err ? 64'd2 : 64'd0);
    check_eq("b_id", 64'(b_id), 64'(id));
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    check_eq("aw_ready_after_b", 64'(aw_ready), 64'd1);
  endtask

  // mode: 0 random r_ready, 1 alternating 1,0,1,0..., 2 always ready.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input int mode);
    int cnt;
    int n;
    int k;
    bit rdy;
    longint a;
    @(negedge clk);
    ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_valid = 1'b1;
    cnt = 0;
    while (!ar_ready && cnt < 100) begin @(negedge clk); cnt++; end
    check_eq("ar_ready_wait", 64'(ar_ready), 64'd1);
    if (!ar_ready) begin ar_valid = 1'b0; return; end
    @(negedge clk);
    ar_valid = 1'b0;
    n = 0;
    k = 0;
    while (n <= int'(len) && k < 2000) begin
      rdy = (mode == 2) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
      r_ready = rdy;
      check_eq("r_valid", 64'(r_valid), 64'd1);
      if (r_valid) begin
        a = beat_addr(addr, n, size);
        check_eq("r_data", r_data, model_read(a));
        check_eq("r_resp", 64'(r_resp), (a >= MemBytes) ? 64'd2 : 64'd0);
        check_eq("r_last", 64'(r_last), 64'(n == int'(len)));
        check_eq("r_id", 64'(r_id), 64'(id));
        if (rdy) n++;
      end else begin
        r_ready = 1'b0;
        return;
      end
      k++;
      @(negedge clk);
    end
    r_ready = 1'b0;
    check_eq("ar_ready_after_r", 64'(ar_ready), 64'd1);
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i <= len; i++) begin
      wr_data[i] = {$urandom, $urandom};
      wr_strb[i] = 8'($urandom);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wa;
    logic [31:0] ra;
    logic [7:0]  wl;
    logic [7:0]  rl;
    logic [2:0]  ws;
    logic [2:0]  rs;
    int          op;

    rst_n = 1'b0;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_valid = 1'b0;
    w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; b_ready = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_valid = 1'b0; r_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_aw_ready", 64'(aw_ready), 64'd0);
    check_eq("rst_ar_ready", 64'(ar_ready), 64'd0);
    check_eq("rst_w_ready", 64'(w_ready), 64'd0);
    check_eq("rst_b_valid", 64'(b_valid), 64'd0);
    check_eq("rst_r_valid", 64'(r_valid), 64'd0);
    check_eq("rst_r_data", r_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("aw_ready_after_rst", 64'(aw_ready), 64'd1);
    check_eq("ar_ready_after_rst", 64'(ar_ready), 64'd1);

    // Establish known contents for the low region and the top-of-memory region.
    for (int i = 0; i < 64; i++) begin wr_data[i] = {$urandom, $urandom}; wr_strb[i] = 8'hFF; end
    do_write(4'd0, 32'h0, 8'd63, 3'd3, -1, 1'b0);
    for (int i = 0; i < 8; i++) begin wr_data[i] = {$urandom, $urandom}; wr_strb[i] = 8'hFF; end
    do_write(4'd0, 32'h7FC0, 8'd7, 3'd3, -1, 1'b0);

    // Single beat write/read back.
    wr_data[0] = 64'h1122334455667788; wr_strb[0] = 8'hFF;
    do_write(4'd3, 32'h10, 8'd0, 3'd3, -1, 1'b0);
    do_read(4'd3, 32'h10, 8'd0, 3'd3, 2);

    // Partial strobe merge.
    wr_data[0] = 64'hFFFFFFFFFFFFFFFF; wr_strb[0] = 8'h0F;
    do_write(4'd2, 32'h10, 8'd0, 3'd3, -1, 1'b0);
    do_read(4'd2, 32'h10, 8'd0, 3'd3, 2);
    check_eq("strb_merge", ref_mem[2], 64'h11223344FFFFFFFF);

    // Four-beat burst with throttled read.
    for (int i = 0; i < 4; i++) begin wr_data[i] = {$urandom, $urandom}; wr_strb[i] = 8'hFF; end
    do_write(4'd1, 32'h0, 8'd3, 3'd3, -1, 1'b1);
    do_read(4'd1, 32'h0, 8'd3, 3'd3, 1);

    // Out of range access and no aliasing into low memory.
    wr_data[0] = 64'hDEADBEEFCAFEF00D; wr_strb[0] = 8'hFF;
    do_write(4'd5, 32'h8000, 8'd0, 3'd3, -1, 1'b0);
    do_read(4'd5, 32'h8000, 8'd0, 3'd3, 2);
    do_read(4'd6, 32'h0, 8'd3, 3'd3, 2);

    // Early WLAST.
    fill_random(1);
    do_write(4'd7, 32'h40, 8'd1, 3'd3, 0, 1'b0);

    // Simultaneous AW and AR.
    fill_random(3);
    fork
      do_write(4'd8, 32'h20, 8'd3, 3'd3, -1, 1'b1);
      do_read(4'd9, 32'h100, 8'd3, 3'd3, 0);
    join

    // Reset in the middle of a read burst.
    @(negedge clk);
    ar_id = 4'd4; ar_addr = 32'h0; ar_len = 8'd7; ar_size = 3'd3; ar_valid = 1'b1;
    check_eq("ar_ready_pre_abort", 64'(ar_ready), 64'd1);
    @(negedge clk);
    ar_valid = 1'b0;
    r_ready  = 1'b1;
    for (int n = 0; n < 2; n++) begin
      check_eq("abort_r_data", r_data, model_read(beat_addr(32'h0, n, 3'd3)));
      @(negedge clk);
    end
    check_eq("abort_r_valid_before", 64'(r_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_r_valid", 64'(r_valid), 64'd0);
    check_eq("abort_ar_ready", 64'(ar_ready), 64'd0);
    check_eq("abort_r_last", 64'(r_last), 64'd0);
    r_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("ar_ready_at_release", 64'(ar_ready), 64'd0);
    @(negedge clk);
    check_eq("ar_ready_one_after", 64'(ar_ready), 64'd1);
    check_eq("b_valid_after_abort", 64'(b_valid), 64'd0);
    do_read(4'd4, 32'h18, 8'd0, 3'd3, 2);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 3));
      wl = 8'($urandom_range(0, 7));
      rl = 8'($urandom_range(0, 7));
      ws = 3'($urandom_range(0, 3));
      rs = 3'($urandom_range(0, 3));
      fill_random(int'(wl));
      case (op)
        0: do_write(4'($urandom), 32'($urandom_range(0, 'h1BF)), wl, ws, -1, 1'b1);
        1: do_read(4'($urandom), 32'($urandom_range(0, 'h1BF)), rl, rs, 0);
        2: begin
          wa = 32'h7FC0 + 32'($urandom_range(0, 'h3F));
          ra = 32'h7FC0 + 32'($urandom_range(0, 'h3F));
          if ($urandom_range(0, 1) == 1) do_write(4'($urandom), wa, wl, ws, -1, 1'b1);
          else do_read(4'($urandom), ra, rl, rs, 0);
        end
        default: begin
          wa = 32'($urandom_range(0, 'h7F));
          ra = 32'h100 + 32'($urandom_range(0, 'h7F));
          fork
            do_write(4'($urandom), wa, wl, ws, -1, 1'b1);
            do_read(4'($urandom), ra, rl, rs, 0);
          join
        end
      endcase
    end
    do_read(4'd0, 32'h0, 8'd63, 3'd3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
